serial_add_ctrl: RTL

Bit-serial adder controller. It time-shares one 1-bit full-adder cell (sum = a^b^c, carry = a&b | c&(a^b)) across a WIDTH-bit addition, processing one bit per clock from LSB to MSB. It has a start/busy/done handshake and sits between a requester (CPU-style sequencer or testbench) and the shared full-adder datapath.

---
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB->MSB, one bit per clock.
// Optional subtract mode compiled in with SERIAL_ADD_SUB_EN (adds the 'sub' input).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_ld_b;
    logic             w_ld_c;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // The single shared full-adder cell.
    assign w_sum    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry  = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force a carry-in of 1.
    assign w_ld_b = sub ? ~b : b;
    assign w_ld_c = sub ? 1'b1 : cin;
`else
    assign w_ld_b = b;
    assign w_ld_c = cin;
`endif

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_sum;
        end else begin : g_res_wn
            assign w_res_next = {w_sum, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= w_ld_b;
                        r_c     <= w_ld_c;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_carry;
                    r_res <= w_res_next;
                    if (w_last) begin
                        sum     <= w_res_next;
                        cout    <= w_carry;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
